// File: rtl/ram_sched_pkg.sv
// ----------------------------------------------------------------------------
// ram_sched_pkg
// Shared types and helpers for the RAM/IO bus sequencer (ram_port_sched).
//   state_e     : sequencer states (IDLE, RD, WR, DONE)
//   owner_e     : which pipeline stage currently owns the bus
//   size_e      : access size codes as presented on mem_size
//   IO_SEL      : value of address bits [17:16] that selects the I/O space
//   beat_count  : access size code -> number of byte beats (1, 2 or 4)
// ----------------------------------------------------------------------------
package ram_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'd0,
        SZ_HALF     = 2'd1,
        SZ_WORD     = 2'd2,
        SZ_WORD_ALT = 2'd3
    } size_e;

    // Address bits [17:16] equal to this value address the I/O space.
    localparam logic [1:0] IO_SEL = 2'b11;

    // Size code 3 is not a legal access size; it is treated as a full word.
    function automatic logic [2:0] beat_count(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/byte_lane_pack.sv
// ----------------------------------------------------------------------------
// byte_lane_pack
// Assembles a 32-bit little-endian word from individual byte writes.
//   clk     in   system clock
//   rst     in   synchronous active-high reset (clears the word)
//   clr_i   in   clear all lanes to zero (takes priority over a lane write)
//   we_i    in   write byte_i into the lane selected by lane_i
//   lane_i  in   [1:0] target lane, lane 0 = bits [7:0]
//   byte_i  in   [7:0] byte to store
//   word_o  out  [31:0] current packed word
// ----------------------------------------------------------------------------
module byte_lane_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        we_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (rst || clr_i) begin
                    lane_q <= '0;
                end else if (we_i && (lane_i == 2'(gi))) begin
                    lane_q <= byte_i;
                end
            end

            assign word_o[gi*8 +: 8] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/ram_port_sched.sv
// ----------------------------------------------------------------------------
// ram_port_sched
// Arbitrates the single 8-bit RAM/IO bus between instruction fetch (IF) and
// the MEM stage. MEM has fixed priority over IF. Each granted word-level
// request is serialised into little-endian byte beats at base+i.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rdy               global ready; everything freezes while low
//   if_req/if_addr    fetch request (always a 4-byte read)
//   if_flush          abandon any pending or in-flight fetch
//   if_done/if_data   one-cycle completion pulse with the fetched word
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata   data request
//   mem_done/mem_rdata                           completion, zero-extended load
//   io_buffer_full    UART buffer full: holds writes to the I/O space
//   ram_din           read byte, valid one cycle after its address
//   ram_dout/ram_addr/ram_wr                     byte bus towards RAM/IO
//   busy              sequencer is not in IDLE
// ----------------------------------------------------------------------------
module ram_port_sched
    import ram_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic        io_buffer_full,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic        busy
);

    // ------------------------------------------------------------------
    // Transaction registers
    // ------------------------------------------------------------------
    state_e      state_q;
    owner_e      owner_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic        mem_we_q;
    logic [2:0]  n_q;          // number of beats in this access
    logic [2:0]  idx_q;        // beats issued so far
    logic        cap_q;        // ram_din carries a byte to capture this cycle
    logic [1:0]  cap_lane_q;   // lane that byte belongs to
    logic        all_cap_q;    // last byte already captured while frozen
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;

    // ------------------------------------------------------------------
    // Beat decode
    // ------------------------------------------------------------------
    logic        in_access;
    logic        beat_active;
    logic [31:0] beat_addr;
    logic [7:0]  wr_byte;
    logic        io_hold;
    logic        beat_issue;
    logic [2:0]  n_m1;
    logic        last_cap;
    logic        grant_mem;
    logic        grant_if;
    logic        flush_now;
    logic        lane_clr;
    logic [31:0] lanes;

    assign in_access   = (state_q == ST_RD) || (state_q == ST_WR);
    assign beat_active = in_access && (idx_q < n_q);
    assign beat_addr   = base_q + {29'd0, idx_q};

    always_comb begin
        wr_byte = wdata_q[7:0];
        case (idx_q[1:0])
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            2'd3:    wr_byte = wdata_q[31:24];
            default: wr_byte = wdata_q[7:0];
        endcase
    end

    // A write beat into the I/O space waits for room in the UART buffer;
    // address and data stay on the bus while it waits.
    assign io_hold    = (state_q == ST_WR) && (beat_addr[17:16] == IO_SEL) && io_buffer_full;
    assign beat_issue = beat_active && rdy && !io_hold;

    assign n_m1     = n_q - 3'd1;
    assign last_cap = cap_q && ({1'b0, cap_lane_q} == n_m1);

    assign grant_mem = (state_q == ST_IDLE) && rdy && mem_req;
    assign grant_if  = (state_q == ST_IDLE) && rdy && !mem_req && if_req && !if_flush;
    assign flush_now = (state_q == ST_RD) && (owner_q == OWN_IF) && if_flush && rdy;

    // Lanes are cleared at every grant so short loads come back zero-extended,
    // and on a flush so an abandoned fetch leaves nothing behind.
    assign lane_clr = grant_mem || grant_if || flush_now;

    byte_lane_pack u_pack (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (lane_clr),
        .we_i   (cap_q),
        .lane_i (cap_lane_q),
        .byte_i (ram_din),
        .word_o (lanes)
    );

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state)
    // ------------------------------------------------------------------
    assign ram_addr = beat_active ? beat_addr : 32'd0;
    assign ram_dout = ((state_q == ST_WR) && beat_active) ? wr_byte : 8'd0;
    assign ram_wr   = (state_q == ST_WR) && beat_issue;
    assign busy     = (state_q != ST_IDLE);

    assign if_done  = (state_q == ST_DONE) && (owner_q == OWN_IF);
    assign mem_done = (state_q == ST_DONE) && (owner_q == OWN_MEM);

    // In DONE the freshly packed word is presented directly; it is copied
    // into the holding register on the way out so it stays until the next
    // completion for the same owner. Stores leave mem_rdata untouched.
    assign if_data   = if_done ? lanes : if_data_q;
    assign mem_rdata = (mem_done && !mem_we_q) ? lanes : mem_rdata_q;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            base_q      <= '0;
            wdata_q     <= '0;
            mem_we_q    <= 1'b0;
            n_q         <= '0;
            idx_q       <= '0;
            cap_q       <= 1'b0;
            cap_lane_q  <= '0;
            all_cap_q   <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            // The byte pipeline from the RAM is not frozen by rdy: a byte
            // addressed in a ready cycle arrives next cycle regardless.
            cap_q      <= (state_q == ST_RD) && beat_issue && !flush_now;
            cap_lane_q <= idx_q[1:0];

            if (rdy) begin
                case (state_q)
                    ST_IDLE: begin
                        idx_q     <= '0;
                        all_cap_q <= 1'b0;
                        if (mem_req) begin
                            owner_q  <= OWN_MEM;
                            base_q   <= mem_addr;
                            wdata_q  <= mem_wdata;
                            mem_we_q <= mem_we;
                            n_q      <= beat_count(mem_size);
                            state_q  <= mem_we ? ST_WR : ST_RD;
                        end else if (if_req && !if_flush) begin
                            owner_q  <= OWN_IF;
                            base_q   <= if_addr;
                            wdata_q  <= '0;
                            mem_we_q <= 1'b0;
                            n_q      <= 3'd4;
                            state_q  <= ST_RD;
                        end
                    end

                    ST_RD: begin
                        if (flush_now) begin
                            state_q <= ST_IDLE;
                        end else begin
                            if (beat_issue) begin
                                idx_q <= idx_q + 3'd1;
                            end
                            if (last_cap || all_cap_q) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end

                    ST_WR: begin
                        if (beat_issue) begin
                            idx_q <= idx_q + 3'd1;
                            if (idx_q == n_m1) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end

                    ST_DONE: begin
                        if (owner_q == OWN_IF) begin
                            if_data_q <= lanes;
                        end else if (!mem_we_q) begin
                            mem_rdata_q <= lanes;
                        end
                        state_q <= ST_IDLE;
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end else if ((state_q == ST_RD) && last_cap) begin
                // Last byte landed while frozen; finish as soon as rdy returns.
                all_cap_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_sched.sv
module tb_ram_port_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        io_buffer_full;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;

    // Scoreboards: expected results pushed when stimulus is driven.
    logic [31:0] exp_if_q[$];
    logic [32:0] exp_mem_q[$];   // {check_data, data}
    logic [39:0] exp_wr_q[$];    // {addr, byte}

    logic [7:0] ram_m [logic [31:0]];

    always #5 clk = ~clk;

    ram_port_sched dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_flush       (if_flush),
        .if_done        (if_done),
        .if_data        (if_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_size       (mem_size),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_done       (mem_done),
        .mem_rdata      (mem_rdata),
        .io_buffer_full (io_buffer_full),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .ram_addr       (ram_addr),
        .ram_wr         (ram_wr),
        .busy           (busy)
    );

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_m.exists(a)) return ram_m[a];
        return 8'h00;
    endfunction

    // RAM model: read data one cycle after the address, writes on ram_wr.
    always @(posedge clk) begin
        if (ram_wr) ram_m[ram_addr] = ram_dout;
        ram_din <= ram_rd(ram_addr);
    end

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_wr) begin
                logic [39:0] e;
                wr_count++;
                checks++;
                $display("write addr=%h dout=%h", ram_addr, ram_dout);
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr=%h dout=%h, required no write", ram_addr, ram_dout);
                end else begin
                    e = exp_wr_q.pop_front();
                    if ({ram_addr, ram_dout} !== e) begin
                        errors++;
                        $display("FAIL wr_beat: got addr=%h dout=%h, required addr=%h dout=%h",
                                 ram_addr, ram_dout, e[39:8], e[7:0]);
                    end
                end
            end
            if (if_done) begin
                logic [31:0] e;
                checks++;
                $display("if_done data=%h", if_data);
                if (exp_if_q.size() == 0) begin
                    errors++;
                    $display("FAIL if_unexpected: got if_done data=%h, required no if_done", if_data);
                end else begin
                    e = exp_if_q.pop_front();
                    if (if_data !== e) begin
                        errors++;
                        $display("FAIL if_data: got %h, required %h", if_data, e);
                    end
                end
            end
            if (mem_done) begin
                logic [32:0] e;
                checks++;
                $display("mem_done rdata=%h", mem_rdata);
                if (exp_mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_unexpected: got mem_done rdata=%h, required no mem_done", mem_rdata);
                end else begin
                    e = exp_mem_q.pop_front();
                    if (e[32] && (mem_rdata !== e[31:0])) begin
                        errors++;
                        $display("FAIL mem_rdata: got %h, required %h", mem_rdata, e[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
        io_buffer_full = 1'b0;
        repeat (3) tick();
        sample();
        checks++;
        if ({busy, ram_wr, if_done, mem_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy/wr/ifd/memd=%b, required 0000", {busy, ram_wr, if_done, mem_done});
        end
        checks++;
        if (ram_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h, required 0", ram_addr); end
        checks++;
        if (ram_dout !== 8'd0) begin errors++; $display("FAIL reset_dout: got %h, required 0", ram_dout); end
        checks++;
        if ({if_data, mem_rdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: got if_data=%h mem_rdata=%h, required 0", if_data, mem_rdata);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_word_fetch();
        ram_m[32'h100] = 8'h13; ram_m[32'h101] = 8'h00; ram_m[32'h102] = 8'h00; ram_m[32'h103] = 8'h00;
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        exp_if_q.push_back(32'h0000_0013);
        sample();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL fetch_idle: got busy=%b, required 0", busy); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            sample();
            checks++;
            if ({ram_wr, ram_addr} !== {1'b0, 32'h100 + 32'(k - 1)}) begin
                errors++;
                $display("FAIL fetch_beat%0d: got wr=%b addr=%h, required wr=0 addr=%h", k, ram_wr, ram_addr, 32'h100 + 32'(k - 1));
            end
        end
        tick();
        sample();
        checks++;
        if (if_done !== 1'b0) begin errors++; $display("FAIL fetch_early_done: got %b, required 0 in cycle 5", if_done); end
        tick();
        sample();
        checks++;
        if (if_done !== 1'b1) begin errors++; $display("FAIL fetch_done: got %b, required 1 in cycle 6", if_done); end
        tick();
        if_req = 1'b0;
        sample();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL fetch_back_idle: got busy=%b, required 0", busy); end
    endtask

    task automatic test_contention();
        int mem_c = -1;
        int beat_c = -1;
        int ifd_c = -1;
        ram_m[32'h204] = 8'hEF; ram_m[32'h205] = 8'hBE;
        ram_m[32'h300] = 8'h78; ram_m[32'h301] = 8'h56; ram_m[32'h302] = 8'h34; ram_m[32'h303] = 8'h12;
        tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd1; mem_addr = 32'h204;
        if_req = 1'b1; if_addr = 32'h300;
        exp_mem_q.push_back({1'b1, 32'h0000_BEEF});
        exp_if_q.push_back(32'h1234_5678);
        for (int c = 1; c <= 20 && ifd_c < 0; c++) begin
            tick();
            if (mem_c >= 0) mem_req = 1'b0;
            sample();
            if (mem_done && mem_c < 0) mem_c = c;
            if (busy && !ram_wr && ram_addr == 32'h300 && beat_c < 0) beat_c = c;
            if (if_done) ifd_c = c;
        end
        tick();
        if_req = 1'b0;
        checks++;
        if (mem_c !== 4) begin errors++; $display("FAIL cont_mem_done: got cycle %0d, required 4", mem_c); end
        checks++;
        if (beat_c !== 6) begin errors++; $display("FAIL cont_if_start: got cycle %0d, required 6", beat_c); end
        checks++;
        if (ifd_c !== 11) begin errors++; $display("FAIL cont_if_done: got cycle %0d, required 11", ifd_c); end
    endtask

    task automatic test_io_store();
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h0003_0000; mem_wdata = 32'hAABB_CC41;
        io_buffer_full = 1'b1;
        exp_wr_q.push_back({32'h0003_0000, 8'h41});
        exp_mem_q.push_back({1'b0, 32'h0});
        sample();
        for (int k = 1; k <= 5; k++) begin
            tick();
            sample();
            checks++;
            if ({ram_wr, ram_addr, ram_dout} !== {1'b0, 32'h0003_0000, 8'h41}) begin
                errors++;
                $display("FAIL io_hold%0d: got wr=%b addr=%h dout=%h, required wr=0 addr=00030000 dout=41", k, ram_wr, ram_addr, ram_dout);
            end
        end
        tick();
        io_buffer_full = 1'b0;
        sample();
        checks++;
        if (ram_wr !== 1'b1) begin errors++; $display("FAIL io_release: got wr=%b, required 1", ram_wr); end
        tick();
        sample();
        checks++;
        if (mem_done !== 1'b1) begin errors++; $display("FAIL io_done: got %b, required 1", mem_done); end
        tick();
        mem_req = 1'b0;
        sample();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL io_idle: got busy=%b, required 0", busy); end
    endtask

    task automatic test_flush();
        int mem_c = -1;
        int ifd_n = 0;
        ram_m[32'h500] = 8'h0D; ram_m[32'h501] = 8'hF0; ram_m[32'h502] = 8'hFE; ram_m[32'h503] = 8'hCA;
        tick();
        if_req = 1'b1; if_addr = 32'h400;
        tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h500;
        exp_mem_q.push_back({1'b1, 32'hCAFE_F00D});
        tick();
        tick();
        if_flush = 1'b1; if_req = 1'b0;
        sample();
        checks++;
        if (ram_addr !== 32'h402) begin errors++; $display("FAIL flush_beat2: got addr=%h, required 00000402", ram_addr); end
        tick();
        if_flush = 1'b0;
        sample();
        checks++;
        if ({busy, if_done} !== 2'b00) begin errors++; $display("FAIL flush_idle: got busy/if_done=%b, required 00", {busy, if_done}); end
        tick();
        sample();
        checks++;
        if ({busy, ram_addr} !== {1'b1, 32'h500}) begin
            errors++;
            $display("FAIL flush_mem_grant: got busy=%b addr=%h, required busy=1 addr=00000500", busy, ram_addr);
        end
        for (int c = 6; c <= 20 && mem_c < 0; c++) begin
            tick();
            sample();
            if (mem_done) mem_c = c;
            if (if_done) ifd_n++;
        end
        tick();
        mem_req = 1'b0;
        checks++;
        if (mem_c !== 10) begin errors++; $display("FAIL flush_mem_done: got cycle %0d, required 10", mem_c); end
        checks++;
        if (ifd_n !== 0) begin errors++; $display("FAIL flush_no_if_done: got %0d pulses, required 0", ifd_n); end
    endtask

    task automatic test_rdy_freeze();
        int mem_c = -1;
        int wr_base;
        wr_base = wr_count;
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h1000; mem_wdata = 32'h4433_2211;
        exp_wr_q.push_back({32'h1000, 8'h11});
        exp_wr_q.push_back({32'h1001, 8'h22});
        exp_wr_q.push_back({32'h1002, 8'h33});
        exp_wr_q.push_back({32'h1003, 8'h44});
        exp_mem_q.push_back({1'b0, 32'h0});
        tick();
        tick();
        for (int k = 3; k <= 5; k++) begin
            tick();
            rdy = 1'b0;
            sample();
            checks++;
            if ({ram_wr, ram_addr} !== {1'b0, 32'h1002}) begin
                errors++;
                $display("FAIL rdy_freeze%0d: got wr=%b addr=%h, required wr=0 addr=00001002", k, ram_wr, ram_addr);
            end
        end
        for (int c = 6; c <= 20 && mem_c < 0; c++) begin
            tick();
            rdy = 1'b1;
            sample();
            if (mem_done) mem_c = c;
        end
        tick();
        mem_req = 1'b0;
        checks++;
        if (mem_c !== 8) begin errors++; $display("FAIL rdy_done: got cycle %0d, required 8", mem_c); end
        checks++;
        if (wr_count - wr_base !== 4) begin errors++; $display("FAIL rdy_wr_count: got %0d, required 4", wr_count - wr_base); end
    endtask

    task automatic test_back_to_back();
        int d1 = -1;
        int d2 = -1;
        ram_m[32'h800] = 8'h01; ram_m[32'h801] = 8'h02; ram_m[32'h802] = 8'h03; ram_m[32'h803] = 8'h04;
        ram_m[32'h900] = 8'hEF; ram_m[32'h901] = 8'hBE; ram_m[32'h902] = 8'hAD; ram_m[32'h903] = 8'hDE;
        tick();
        if_req = 1'b1; if_addr = 32'h800;
        exp_if_q.push_back(32'h0403_0201);
        for (int c = 1; c <= 30 && d2 < 0; c++) begin
            tick();
            if (d1 >= 0 && if_addr == 32'h800) begin
                if_addr = 32'h900;
                exp_if_q.push_back(32'hDEAD_BEEF);
            end
            sample();
            if (if_done) begin
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
        end
        tick();
        if_req = 1'b0;
        checks++;
        if (d1 !== 6) begin errors++; $display("FAIL b2b_first: got cycle %0d, required 6", d1); end
        checks++;
        if (d2 !== 13) begin errors++; $display("FAIL b2b_second: got cycle %0d, required 13", d2); end
    endtask

    task automatic test_mid_reset();
        int mem_c = -1;
        ram_m[32'h600] = 8'h11; ram_m[32'h601] = 8'h22; ram_m[32'h602] = 8'h33; ram_m[32'h603] = 8'h44;
        tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h600;
        tick();
        tick();
        rst = 1'b1; mem_req = 1'b0;
        tick();
        rst = 1'b0;
        sample();
        checks++;
        if ({busy, ram_wr, mem_done, if_done, ram_addr, ram_dout} !== 44'd0) begin
            errors++;
            $display("FAIL mid_reset_outs: got busy=%b wr=%b md=%b id=%b addr=%h dout=%h, required all 0",
                     busy, ram_wr, mem_done, if_done, ram_addr, ram_dout);
        end
        checks++;
        if ({if_data, mem_rdata} !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset_data: got if_data=%h mem_rdata=%h, required 0", if_data, mem_rdata);
        end
        tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h601;
        exp_mem_q.push_back({1'b1, 32'h0000_0022});
        for (int c = 1; c <= 12 && mem_c < 0; c++) begin
            tick();
            sample();
            if (mem_done) mem_c = c;
        end
        tick();
        mem_req = 1'b0;
        checks++;
        if (mem_c !== 3) begin errors++; $display("FAIL mid_reset_fresh: got done cycle %0d, required 3", mem_c); end
    endtask

    initial begin
        test_reset();
        test_word_fetch();
        test_contention();
        test_io_store();
        test_flush();
        test_rdy_freeze();
        test_back_to_back();
        test_mid_reset();
        repeat (3) tick();
        checks++;
        if (exp_if_q.size() + exp_mem_q.size() + exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got if=%0d mem=%0d wr=%0d outstanding, required 0",
                     exp_if_q.size(), exp_mem_q.size(), exp_wr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
